// File: rtl/array_multiplier_nxn_if.sv
// ============================================================================
// Module   : array_multiplier_nxn_if
// Brief    : Operand/result bundle for the NxN unsigned array multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface array_multiplier_nxn_if #(
  parameter int N = 8
);
  logic           in_valid;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic [2*N-1:0] Prod;
  logic           out_valid;

  modport master (
    output in_valid, A, B,
    input  Prod, out_valid
  );

  modport slave (
    input  in_valid, A, B,
    output Prod, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/array_multiplier_nxn.sv
// ============================================================================
// Module   : array_multiplier_nxn
// Brief    : Unsigned NxN array multiplier (AND partial products reduced by
//            N-1 ripple-carry rows) with a registered 2N-bit product.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module array_multiplier_nxn_ha (
  input  wire logic i_a,
  input  wire logic i_b,
  output logic      o_s,
  output logic      o_co
);
  assign o_s  = i_a ^ i_b;
  assign o_co = i_a & i_b;
endmodule

module array_multiplier_nxn_fa (
  input  wire logic i_a,
  input  wire logic i_b,
  input  wire logic i_ci,
  output logic      o_s,
  output logic      o_co
);
  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module array_multiplier_nxn #(
  parameter int N = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  array_multiplier_nxn_if.slave bus
);
  logic [2*N-1:0] w_prod;
  logic [2*N-1:0] r_prod;
  logic           r_out_valid;

  // Row r holds the running sum shifted right by r: bit 0 is final product
  // bit r, bits N:1 are carried into the next row alongside pp[r+1].
  for (genvar r = 0; r < N; r++) begin : g_row
    logic [N-1:0] w_pp;
    logic [N:0]   w_acc;

    assign w_pp      = bus.A & {N{bus.B[r]}};
    assign w_prod[r] = w_acc[0];

    if (r == 0) begin : g_first
      assign w_acc = {1'b0, w_pp};
    end else begin : g_add
      for (genvar j = 0; j < N; j++) begin : g_bit
        logic w_s;
        logic w_co;

        assign w_acc[j] = w_s;

        if (j == 0) begin : g_ha
          array_multiplier_nxn_ha u_ha (
            .i_a  (g_row[r-1].w_acc[j+1]),
            .i_b  (w_pp[j]),
            .o_s  (w_s),
            .o_co (w_co)
          );
        end else begin : g_fa
          array_multiplier_nxn_fa u_fa (
            .i_a  (g_row[r-1].w_acc[j+1]),
            .i_b  (w_pp[j]),
            .i_ci (g_bit[j-1].w_co),
            .o_s  (w_s),
            .o_co (w_co)
          );
        end
      end
      assign w_acc[N] = g_bit[N-1].w_co;
    end
  end

  assign w_prod[2*N-1:N] = g_row[N-1].w_acc[N:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_prod <= w_prod;
      end
    end
  end

  assign bus.Prod      = r_prod;
  assign bus.out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_array_multiplier_nxn.sv
// ============================================================================
// Module   : tb_array_multiplier_nxn
// Brief    : Directed table plus random/exhaustive checks of the multiplier
//            at N=8 and N=4 against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_array_multiplier_nxn;
  logic clk;
  logic rst;

  array_multiplier_nxn_if #(.N(8)) bus8 ();
  array_multiplier_nxn_if #(.N(4)) bus4 ();

  array_multiplier_nxn #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  array_multiplier_nxn #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] m8_prod;
  logic        m8_valid;
  logic [7:0]  m4_prod;
  logic        m4_valid;

  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_prod;
    logic        exp_valid;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on both DUTs, advance the reference, clock.
  task automatic cycle(input logic r, input logic v8, input logic [7:0] a8, input logic [7:0] b8,
                       input logic v4, input logic [3:0] a4, input logic [3:0] b4);
    rst           = r;
    bus8.in_valid = v8;
    bus8.A        = a8;
    bus8.B        = b8;
    bus4.in_valid = v4;
    bus4.A        = a4;
    bus4.B        = b4;
    if (r) begin
      m8_prod = '0; m8_valid = 1'b0;
      m4_prod = '0; m4_valid = 1'b0;
    end else begin
      m8_valid = v8;
      if (v8) m8_prod = 16'(a8) * 16'(b8);
      m4_valid = v4;
      if (v4) m4_prod = 8'(a4) * 8'(b4);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " prod8"},  32'(bus8.Prod),      32'(m8_prod));
    chk({tag, " valid8"}, 32'(bus8.out_valid), 32'(m8_valid));
    chk({tag, " prod4"},  32'(bus4.Prod),      32'(m4_prod));
    chk({tag, " valid4"}, 32'(bus4.out_valid), 32'(m4_valid));
  endtask

  initial begin
    m8_prod = '0; m8_valid = 1'b0; m4_prod = '0; m4_valid = 1'b0;

    //         rst   v     A      B      Prod      out_valid
    tbl[0]  = '{1'b1, 1'b1, 8'd200, 8'd100, 16'd0,     1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'd200, 8'd100, 16'd0,     1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'd200, 8'd100, 16'd20000, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 8'd13,  8'd17,  16'd221,   1'b1};
    tbl[4]  = '{1'b0, 1'b1, 8'd0,   8'd255, 16'd0,     1'b1};
    tbl[5]  = '{1'b0, 1'b1, 8'd1,   8'd173, 16'd173,   1'b1};
    tbl[6]  = '{1'b0, 1'b1, 8'd255, 8'd255, 16'hFE01,  1'b1};
    tbl[7]  = '{1'b0, 1'b1, 8'd200, 8'd100, 16'd20000, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 8'd7,   8'd9,   16'd20000, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 8'd9,   8'd7,   16'd20000, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'd255, 8'd255, 16'd20000, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 8'd50,  8'd4,   16'd0,     1'b0};
    tbl[12] = '{1'b0, 1'b1, 8'd50,  8'd4,   16'd200,   1'b1};
    tbl[13] = '{1'b0, 1'b1, 8'd173, 8'd1,   16'd173,   1'b1};
    tbl[14] = '{1'b0, 1'b1, 8'd255, 8'd0,   16'd0,     1'b1};

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].b, 1'b0, 4'd0, 4'd0);
      chk($sformatf("tbl%0d prod", i),  32'(bus8.Prod),      32'(tbl[i].exp_prod));
      chk($sformatf("tbl%0d valid", i), 32'(bus8.out_valid), 32'(tbl[i].exp_valid));
    end

    // N=4 boundary: max*max after a reset, then hold across idle cycles.
    cycle(1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 4'd15, 4'd15);
    chk("n4 rst prod", 32'(bus4.Prod), 32'd0);
    cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 4'd15, 4'd15);
    chk("n4 max prod", 32'(bus4.Prod), 32'd225);
    chk("n4 max valid", 32'(bus4.out_valid), 32'd1);
    cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 4'd3, 4'd5);
    chk("n4 hold prod", 32'(bus4.Prod), 32'd225);
    chk("n4 hold valid", 32'(bus4.out_valid), 32'd0);

    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(63) == 0), 1'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), 4'($urandom), 4'($urandom));
      chk_model("rand");
    end

    for (int i = 0; i < 256; i++) begin
      cycle(1'b0, 1'($urandom), 8'(i), 8'(255 - i), 1'b1, 4'(i >> 4), 4'(i));
      chk_model("exh");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
